// File: rtl/btb_pkg.sv
// Shared BTB types and PC field helpers, used by both the write and read sides.
package btb_pkg;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned IDX_WIDTH = 6;
    localparam int unsigned TAG_WIDTH = WIDTH - IDX_WIDTH - 2;

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;
        logic [WIDTH-1:0]     target;
    } btb_entry_t;

    typedef enum logic {
        StInit,
        StRun
    } btb_wr_state_e;

    // The word-offset bits of the PC are never part of the index or tag.
    function automatic logic [IDX_WIDTH-1:0] btb_idx(input logic [WIDTH-1:0] pc);
        return IDX_WIDTH'(pc >> 2);
    endfunction

    function automatic logic [TAG_WIDTH-1:0] btb_tag(input logic [WIDTH-1:0] pc);
        return TAG_WIDTH'(pc >> (IDX_WIDTH + 2));
    endfunction

endpackage

// File: rtl/btb_wr_fifo.sv
// Small synchronous FIFO of pending BTB writes (entry plus index).
import btb_pkg::*;

module btb_wr_fifo #(
    parameter int unsigned depth     = 4,
    parameter int unsigned idx_width = IDX_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  btb_entry_t           push_entry,
    input  logic [idx_width-1:0] push_idx,
    input  logic                 pop,
    output btb_entry_t           head_entry,
    output logic [idx_width-1:0] head_idx,
    output logic                 full,
    output logic                 empty
);

    localparam int unsigned PtrW = $clog2(depth);

    btb_entry_t           mem_entry [depth];
    logic [idx_width-1:0] mem_idx   [depth];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]        count_q, count_d;
    logic                 do_push, do_pop;

    assign full    = (count_q == (PtrW + 1)'(depth));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_entry = mem_entry[rd_ptr_q];
    assign head_idx   = mem_idx[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_entry[wr_ptr_q] <= push_entry;
            mem_idx[wr_ptr_q]   <= push_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/btb_writer.sv
// BTB write-port controller: post-reset invalidate sweep, then FIFO-buffered branch updates.
// Optional macro BTB_WR_INVALIDATE_EN: not-taken resolutions invalidate their BTB index.
import btb_pkg::*;

module btb_writer #(
    parameter int unsigned width     = WIDTH,
    parameter int unsigned idx_width = IDX_WIDTH,
    parameter int unsigned tag_width = width - idx_width - 2,
    parameter int unsigned depth     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 res_valid,
    output logic                 res_ready,
    input  logic [width-1:0]     res_pc,
    input  logic [width-1:0]     res_target,
    input  logic                 res_taken,
    input  logic                 hold,
    output logic                 btb_load,
    output logic [idx_width-1:0] btb_w_idx,
    output logic                 btb_valid_out,
    output logic [tag_width-1:0] btb_tag_out,
    output logic [width-1:0]     btb_target_out,
    output logic                 init_done
);

`ifdef BTB_WR_INVALIDATE_EN
    localparam bit InvalidateEn = 1'b1;
`else
    localparam bit InvalidateEn = 1'b0;
`endif

    btb_wr_state_e        state;
    logic [idx_width-1:0] sweep_cnt;
    logic                 sweep_armed;

    btb_entry_t           push_entry, head_entry;
    logic [idx_width-1:0] head_idx;
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;

    // Sweep is held off for the first cycle after reset release so the write
    // strobe reads 0 while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StInit;
            sweep_cnt   <= '0;
            sweep_armed <= 1'b0;
            init_done   <= 1'b0;
        end else begin
            sweep_armed <= 1'b1;
            unique case (state)
                StInit: begin
                    if (sweep_armed) begin
                        sweep_cnt <= sweep_cnt + idx_width'(1);
                        if (sweep_cnt == '1) begin
                            state     <= StRun;
                            init_done <= 1'b1;
                        end
                    end
                end
                StRun: ;
                default: state <= StInit;
            endcase
        end
    end

    always_comb begin
        push_entry        = '0;
        push_entry.valid  = res_taken;
        push_entry.tag    = btb_tag(res_pc);
        push_entry.target = res_taken ? res_target : '0;
    end

    assign res_ready = (state == StRun) && !fifo_full;
    // Not-taken records still complete the handshake; they only enqueue when invalidation is on.
    assign fifo_push = res_valid && res_ready && (res_taken || InvalidateEn);
    assign fifo_pop  = (state == StRun) && !fifo_empty && !hold;

    always_comb begin
        btb_load       = 1'b0;
        btb_w_idx      = '0;
        btb_valid_out  = 1'b0;
        btb_tag_out    = '0;
        btb_target_out = '0;
        if (state == StInit) begin
            btb_load  = sweep_armed;
            btb_w_idx = sweep_cnt;
        end else if (fifo_pop) begin
            btb_load       = 1'b1;
            btb_w_idx      = head_idx;
            btb_valid_out  = head_entry.valid;
            btb_tag_out    = head_entry.tag;
            btb_target_out = head_entry.target;
        end
    end

    btb_wr_fifo #(
        .depth     (depth),
        .idx_width (idx_width)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_entry (push_entry),
        .push_idx   (btb_idx(res_pc)),
        .pop        (fifo_pop),
        .head_entry (head_entry),
        .head_idx   (head_idx),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

endmodule

// File: tb/tb_btb_writer.sv
// Self-checking bench for btb_writer: directed table, corner sequences and a queue-based model.
module tb_btb_writer;

    localparam int NE = 64;
    localparam int D  = 4;
`ifdef BTB_WR_INVALIDATE_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        res_valid = 1'b0, res_taken = 1'b0, hold = 1'b0;
    logic [31:0] res_pc = '0, res_target = '0;
    logic        res_ready, btb_load, btb_valid_out, init_done;
    logic [5:0]  btb_w_idx;
    logic [23:0] btb_tag_out;
    logic [31:0] btb_target_out;

    always #5 clk = ~clk;

    btb_writer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_pc         (res_pc),
        .res_target     (res_target),
        .res_taken      (res_taken),
        .hold           (hold),
        .btb_load       (btb_load),
        .btb_w_idx      (btb_w_idx),
        .btb_valid_out  (btb_valid_out),
        .btb_tag_out    (btb_tag_out),
        .btb_target_out (btb_target_out),
        .init_done      (init_done)
    );

    typedef struct {
        logic [5:0]  idx;
        logic [23:0] tag;
        logic [31:0] tgt;
        logic        v;
    } rec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        tk;
        logic        exp_load;
        logic [62:0] exp_data;  // {idx, valid, tag, target}
    } vec_t;

    rec_t q[$];
    vec_t tbl[4];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [62:0] wr_data();
        return {btb_w_idx, btb_valid_out, btb_tag_out, btb_target_out};
    endfunction

    // Model: PC fields by plain arithmetic, FIFO as a queue.
    function automatic rec_t mk_rec(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        rec_t r;
        r.idx = 6'((pc / 4) % NE);
        r.tag = 24'(pc / 256);
        r.tgt = tk ? tgt : 32'h0;
        r.v   = tk;
        return r;
    endfunction

    // One RUN-state cycle: drive, compare against the model, advance the model.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic tk, input logic h);
        logic exp_ready, exp_load;
        @(negedge clk);
        res_valid = v; res_pc = pc; res_target = tgt; res_taken = tk; hold = h;
        #1;
        exp_ready = (q.size() < D);
        exp_load  = (q.size() != 0) && !h;
        chk("ready", res_ready, exp_ready);
        chk("load", btb_load, exp_load);
        if (exp_load)
            chk("wr_data", wr_data(), {q[0].idx, q[0].v, q[0].tag, q[0].tgt});
        else
            chk("idle_data", wr_data(), 63'h0);
        if (exp_load) void'(q.pop_front());
        if (v && exp_ready && (tk || INV)) q.push_back(mk_rec(pc, tgt, tk));
    endtask

    task automatic check_reset_vals(input string name);
        chk(name, {res_ready, btb_load, init_done}, 3'b000);
        chk({name, "_data"}, wr_data(), 63'h0);
    endtask

    task automatic apply_reset();
        res_valid = 1'b0; hold = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_vals");
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Follow the sweep after reset release; stop_at >= 0 returns mid-sweep.
    task automatic sweep_check(input int stop_at);
        int waited = 0;
        @(negedge clk); #1;
        while (!btb_load && waited < 4) begin
            @(negedge clk); #1;
            waited++;
        end
        chk("sweep_start", btb_load, 1'b1);
        for (int i = 0; i < NE; i++) begin
            if (i > 0) begin
                @(negedge clk); #1;
            end
            chk("sweep_ctl", {btb_load, res_ready, init_done, btb_w_idx}, {3'b100, 6'(i)});
            chk("sweep_data", {btb_valid_out, btb_tag_out, btb_target_out}, 57'h0);
            if (i == stop_at) return;
        end
        @(negedge clk); #1;
        chk("init_done", {init_done, res_ready, btb_load}, 3'b110);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nloads;

        tbl[0] = '{32'h0000_0104, 32'h0000_0200, 1'b1, 1'b1,
                   {6'h01, 1'b1, 24'h000001, 32'h0000_0200}};
        tbl[1] = INV ? '{32'h0000_0104, 32'h0000_0300, 1'b0, 1'b1,
                         {6'h01, 1'b0, 24'h000001, 32'h0}}
                     : '{32'h0000_0104, 32'h0000_0300, 1'b0, 1'b0, 63'h0};
        tbl[2] = '{32'hDEAD_BEFC, 32'h1234_5678, 1'b1, 1'b1,
                   {6'h3F, 1'b1, 24'hDEADBE, 32'h1234_5678}};
        tbl[3] = '{32'hFFFF_FF00, 32'hFFFF_FFFC, 1'b1, 1'b1,
                   {6'h00, 1'b1, 24'hFFFFFF, 32'hFFFF_FFFC}};

        #2;
        apply_reset();
        sweep_check(-1);

        // Directed single records: visible on the write port one cycle after acceptance.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, tbl[i].pc, tbl[i].tgt, tbl[i].tk, 1'b0);
            @(negedge clk);
            res_valid = 1'b0;
            #1;
            chk("tbl_load", btb_load, tbl[i].exp_load);
            chk("tbl_data", wr_data(), tbl[i].exp_data);
            if (q.size() > 0) void'(q.pop_front());
        end

        // Full with hold: five offers, only four accepted, drained in order.
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 32'h0000_1000 + 32'(i * 4), 32'h0000_8000 + 32'(i * 16), 1'b1, 1'b1);
        chk("full_ready", res_ready, 1'b0);
        repeat (4) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("drained_ready", res_ready, 1'b1);

        // Pipelined flow: ten accepts back to back, ten consecutive writes.
        nloads = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'h0004_0000 + 32'(i * 4), 32'h00A0_0000 + 32'(i), 1'b1, 1'b0);
            if (btb_load) nloads++;
            chk("pipe_occ", q.size() <= 1, 1'b1);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        if (btb_load) nloads++;
        chk("pipe_writes", nloads, 10);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 3));
        repeat (D + 1) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Reset with three queued records: none may ever be written.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h0000_2000 + 32'(i * 4), 32'h5555_0000, 1'b1, 1'b1);
        apply_reset();
        sweep_check(-1);
        repeat (6) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Reset mid-sweep at index 20: sweep restarts from 0.
        apply_reset();
        sweep_check(20);
        apply_reset();
        sweep_check(-1);
        cycle(1'b1, 32'h0000_0104, 32'h0000_0200, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
